btn_cmd_conditioner: RTL and testbench

Upstream front end for the memory command writer. It takes the three raw active-low board pushbuttons and the 8 slide switches. It synchronizes and debounces the buttons, detects presses, and arbitrates between simultaneous presses. Each accepted press becomes exactly one clean command on the active-low 3-bit btn bus (3'b110 / 3'b101 / 3'b011, idle 3'b111). The block also holds a stable bytePos value captured from the switches. The downstream writer is combinational, so one pulse cycle produces exactly one memory write.

---
 rtl/btn_cmd_conditioner_if.sv | 26 ++
 rtl/btn_cmd_conditioner.sv | 202 ++++++++++++++++++++
 tb/tb_btn_cmd_conditioner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_cmd_conditioner_if.sv
// Bundle between the pushbutton/switch front end and the memory command writer.
// The master side drives the raw board inputs and observes the command outputs.
// The slave side is the conditioner itself.
interface btn_cmd_conditioner_if;
    logic [2:0] btn_n_in;   // raw pushbuttons, active-low, asynchronous
    logic [7:0] sw_in;      // raw slide switches, asynchronous
    logic [2:0] btn;        // active-low command code, 3'b111 when idle
    logic [7:0] bytePos;    // byte position captured on a bit2 command
    logic       busy;       // high whenever the sequencer is not idle

    modport master (
        output btn_n_in,
        output sw_in,
        input  btn,
        input  bytePos,
        input  busy
    );

    modport slave (
        input  btn_n_in,
        input  sw_in,
        output btn,
        output bytePos,
        output busy
    );
endinterface

// File: rtl/btn_cmd_conditioner.sv
// Pushbutton/switch front end for the memory command writer.
// Raw buttons are synchronized and debounced. A debounced press becomes exactly
// one command code on the active-low btn bus. The code is held for PULSE_CYCLES
// cycles, and the next command is accepted only after every button has been
// released. bytePos is captured from the synchronized switches, and only on a
// bit2 command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | btn=111, waiting for a debounced press
// PULSE    | driving the winning command code for PULSE_CYCLES cycles
// WAIT_REL | btn=111, waiting until all debounced buttons are released
//
// CNT_W must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, PULSE_CYCLES).
module btn_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 1,
    parameter int CNT_W           = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    btn_cmd_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       CODE_IDLE  = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Synchronizer flops. Buttons rest at 1 (released); switches rest at 0.
    logic [2:0]       btn_meta_q;
    logic [2:0]       btn_sync_q;
    logic [7:0]       sw_meta_q;
    logic [7:0]       sw_sync_q;

    // Debounce state, one counter per button.
    logic [2:0]       db_q;
    logic [2:0]       db_d;
    logic [2:0]       db_prev_q;
    logic [CNT_W-1:0] db_cnt_q [3];
    logic [CNT_W-1:0] db_cnt_d [3];

    // Press strobes and arbitration result.
    logic [2:0]       press;
    logic [2:0]       win_code;
    logic             win_bit2;

    // Sequencer state and registered outputs.
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic [CNT_W-1:0] pulse_cnt_d;
    logic [2:0]       btn_q;
    logic [2:0]       btn_d;
    logic [7:0]       bytepos_q;
    logic [7:0]       bytepos_d;
    logic             busy_q;
    logic             busy_d;

    // Two-flop synchronizers for the asynchronous buttons and switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 3'b111;
            btn_sync_q <= 3'b111;
            sw_meta_q  <= 8'h00;
            sw_sync_q  <= 8'h00;
        end else begin
            btn_meta_q <= bus.btn_n_in;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.sw_in;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Debounce: a level moves only after DEBOUNCE_CYCLES consecutive cycles
    // of disagreement. A single agreeing cycle restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_sync_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = btn_sync_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Debounce registers. db_prev_q is one cycle behind, for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q      <= 3'b111;
            db_prev_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // A press is a one-cycle strobe when a debounced level falls from 1 to 0.
    assign press = db_prev_q & ~db_q;

    // Fixed-priority arbitration (bit0 > bit1 > bit2). Losing presses are dropped.
    always_comb begin
        win_code = CODE_IDLE;
        win_bit2 = 1'b0;
        if (press[0]) begin
            win_code = 3'b110;
        end else if (press[1]) begin
            win_code = 3'b101;
        end else if (press[2]) begin
            win_code = 3'b011;
            win_bit2 = 1'b1;
        end
    end

    // Next-state logic and next values for the registered outputs.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        btn_d       = btn_q;
        bytepos_d   = bytepos_q;

        case (state_q)
            IDLE: begin
                btn_d       = CODE_IDLE;
                pulse_cnt_d = '0;
                if (|press) begin
                    btn_d   = win_code;
                    state_d = PULSE;
                    // The switch value is captured in the same edge that loads the code.
                    if (win_bit2) begin
                        bytepos_d = sw_sync_q;
                    end
                end
            end

            PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    btn_d       = CODE_IDLE;
                    pulse_cnt_d = '0;
                    state_d     = WAIT_REL;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + CNT_ONE;
                end
            end

            WAIT_REL: begin
                btn_d = CODE_IDLE;
                // Press strobes are ignored here. Wait for every button to be released.
                if (&db_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                btn_d       = CODE_IDLE;
                pulse_cnt_d = '0;
                state_d     = IDLE;
            end
        endcase

        // busy is registered from the next state, so it rises with the code.
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            btn_q       <= CODE_IDLE;
            bytepos_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            btn_q       <= btn_d;
            bytepos_q   <= bytepos_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.btn     = btn_q;
    assign bus.bytePos = bytepos_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Directed bench for btn_cmd_conditioner with DEBOUNCE_CYCLES=4, PULSE_CYCLES=1.
// Stimulus pushes each expected command pulse (code, first cycle, bytePos) into a
// queue. A monitor pops and compares an entry whenever btn leaves 3'b111.
// Inputs change 1 time unit after a rising edge. When that happens with
// cyc == N, the pulse is visible in cycle N+7.
module tb_btn_cmd_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_cmd_conditioner_if bif ();

    btn_cmd_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (1),
        .CNT_W          (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    typedef struct {
        logic [2:0] code;
        int         at_cyc;
        logic [7:0] bp;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       cur;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       in_pulse = 1'b0;
    int         plen     = 0;
    logic [2:0] pcode    = 3'b111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Move to 1 time unit after the rising edge that makes cyc == t.
    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move to the falling edge inside cycle t.
    task automatic sample_at(input int t);
        to_cyc(t);
        @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [2:0] code, input int at_cyc, input logic [7:0] bp);
        exp_t e;
        e.code   = code;
        e.at_cyc = at_cyc;
        e.bp     = bp;
        exp_q.push_back(e);
    endtask

    // Release every button and confirm the sequencer is idle after the release latency.
    task automatic release_all(input string name);
        int r;
        to_cyc(cyc + 1);
        bif.btn_n_in = 3'b111;
        r = cyc;
        sample_at(r + 7);
        check(name, bif.busy, 1'b0);
        to_cyc(cyc + 2);
    endtask

    // Monitor: compares every command pulse against the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else if (bif.btn != 3'b111) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                plen     = 1;
                pcode    = bif.btn;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", bif.btn, 3'b111);
                end else begin
                    cur = exp_q.pop_front();
                    check("pulse_code", bif.btn, cur.code);
                    check("pulse_cycle", cyc, cur.at_cyc);
                    check("pulse_bytepos", bif.bytePos, cur.bp);
                    check("pulse_busy", bif.busy, 1'b1);
                end
            end else begin
                plen++;
                check("pulse_code_stable", bif.btn, pcode);
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("pulse_len", plen, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;

        rst          = 1'b1;
        bif.btn_n_in = 3'b111;
        bif.sw_in    = 8'h00;
        to_cyc(3);
        rst = 1'b0;
        to_cyc(8);

        // Test 1: asynchronous reset asserted mid-cycle with no button pressed.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_btn", bif.btn, 3'b111);
        check("rst_bytepos", bif.bytePos, 8'h00);
        check("rst_busy", bif.busy, 1'b0);
        to_cyc(cyc + 2);
        rst = 1'b0;
        to_cyc(cyc + 3);

        // Test 2: clean bit0 press held 30 cycles. Exactly one 110 pulse in cycle N+7.
        n = cyc;
        bif.btn_n_in = 3'b110;
        expect_pulse(3'b110, n + 7, 8'h00);
        sample_at(n + 6);
        check("t2_busy_before", bif.busy, 1'b0);
        check("t2_btn_before", bif.btn, 3'b111);
        sample_at(n + 8);
        check("t2_btn_after", bif.btn, 3'b111);
        check("t2_busy_held", bif.busy, 1'b1);
        to_cyc(n + 30);
        bif.btn_n_in = 3'b111;
        sample_at(n + 36);
        check("t2_busy_until_release", bif.busy, 1'b1);
        sample_at(n + 37);
        check("t2_busy_released", bif.busy, 1'b0);
        to_cyc(cyc + 3);

        // Test 3: bounce bit1 every 2 cycles for 12 cycles, then hold low.
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            to_cyc(n + 2 * k);
            bif.btn_n_in[1] = k[0];
        end
        to_cyc(n + 12);
        bif.btn_n_in[1] = 1'b0;
        expect_pulse(3'b101, n + 19, 8'h00);
        to_cyc(n + 35);
        release_all("t3_idle");

        // Test 4: bit2 captures the switches, and a later bit0 press leaves bytePos unchanged.
        bif.sw_in = 8'h2A;
        to_cyc(cyc + 4);
        n = cyc;
        bif.btn_n_in = 3'b011;
        expect_pulse(3'b011, n + 7, 8'h2A);
        to_cyc(n + 15);
        release_all("t4_idle_a");
        bif.sw_in = 8'h55;
        to_cyc(cyc + 4);
        n = cyc;
        bif.btn_n_in = 3'b110;
        expect_pulse(3'b110, n + 7, 8'h2A);
        sample_at(n + 12);
        check("t4_bytepos_kept", bif.bytePos, 8'h2A);
        to_cyc(n + 15);
        release_all("t4_idle_b");

        // Test 5: simultaneous bit0 and bit2. Only 110 is emitted; a later bit2 press alone gives 011.
        n = cyc;
        bif.btn_n_in = 3'b010;
        expect_pulse(3'b110, n + 7, 8'h2A);
        to_cyc(n + 15);
        release_all("t5_idle_a");
        n = cyc;
        bif.btn_n_in = 3'b011;
        expect_pulse(3'b011, n + 7, 8'h55);
        to_cyc(n + 15);
        release_all("t5_idle_b");

        // Test 6: reset during a pulse. After rst is released, the held button is a fresh press.
        n = cyc;
        bif.btn_n_in = 3'b110;
        to_cyc(n + 7);
        #1;
        check("t6_mid_pulse", bif.btn, 3'b110);
        rst = 1'b1;
        #1;
        check("t6_rst_btn", bif.btn, 3'b111);
        check("t6_rst_busy", bif.busy, 1'b0);
        check("t6_rst_bytepos", bif.bytePos, 8'h00);
        to_cyc(cyc + 3);
        m = cyc;
        rst = 1'b0;
        expect_pulse(3'b110, m + 7, 8'h00);
        to_cyc(m + 20);
        release_all("t6_idle");

        to_cyc(cyc + 10);
        check("queue_empty", exp_q.size(), 0);
        check("no_pulse_open", in_pulse, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
